// File: rtl/demux1_4_router_pkg.sv
// Shared constants and types for the 1:4 demux router.
// Contents: data/counter widths, channel count, select width, and the
// per-channel holding-buffer state enum.
package demux_pkg;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;
endpackage

// File: rtl/demux1_4_router_if.sv
// Bus interface of the 1:4 demux router.
// Source side : in_valid, in_ready, in_data, in_sel
// Sink side   : out_valid[3:0], out_ready[3:0], out_data0..3, out_cnt
// Handshake   : a word moves on any cycle where valid and ready are both 1.
//               Valid, once raised, holds with stable data until accepted;
//               ready may be computed combinationally from the other side's
//               state but never from valid.
// Modports    : master = the source/sink environment, slave = the router.
interface demux1_4_router_if;
  import demux_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [DATA_W-1:0]       out_data0;
  logic [DATA_W-1:0]       out_data1;
  logic [DATA_W-1:0]       out_data2;
  logic [DATA_W-1:0]       out_data3;
  logic [NUM_CH*CNT_W-1:0] out_cnt;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
           out_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
           out_cnt
  );
endinterface

// File: rtl/demux1_4_router_chan_buf.sv
// One-entry registered holding buffer with a delivered-word counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : load i_data this cycle (only asserted when the slot is free
//                or being popped in the same cycle)
//   i_data     : word to load
//   i_ready    : sink accepts the held word
//   o_valid    : slot holds a word
//   o_data     : held word (holds its last value after a pop)
//   o_cnt      : number of words delivered, wrapping
//   o_state    : current buffer state, for observation
module demux_chan_buf
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_cnt,
  output chan_state_t       o_state
);
  chan_state_t       r_state;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_pop;

  assign w_pop = (r_state == FULL) & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_pop) r_cnt <= r_cnt + CNT_W'(1);
      case (r_state)
        EMPTY: begin
          if (i_push) begin
            r_state <= FULL;
            r_data  <= i_data;
          end
        end
        FULL: begin
          // A push while FULL implies a same-cycle pop: refill without a bubble.
          if (i_push) r_data <= i_data;
          else if (i_ready) r_state <= EMPTY;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign o_valid = (r_state == FULL);
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;
  assign o_state = r_state;
endmodule

// File: rtl/demux1_4_router.sv
// 1:4 demux router: steers one source word stream into one of four
// one-entry sink buffers, one clock from acceptance to out_valid.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_bcast     : (only with DEMUX_BCAST_EN) push the word into all channels
//   bus          : demux1_4_router_if slave (source + four sinks + counters)
//   o_dbg_state  : per-channel buffer state
// Build option: define DEMUX_BCAST_EN to add the broadcast input.
module demux1_4_router
  import demux_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef DEMUX_BCAST_EN
  input  logic                     in_bcast,
`endif
  demux1_4_router_if.slave         bus,
  output chan_state_t [NUM_CH-1:0] o_dbg_state
);
  logic [NUM_CH-1:0] w_valid;
  logic [NUM_CH-1:0] w_push;
  logic [DATA_W-1:0] w_data [NUM_CH];
  logic [CNT_W-1:0]  w_cnt  [NUM_CH];
  logic              w_sel_ok;
  logic              w_bcast;
  logic              w_fire;

  // Readiness looks only at the addressed channel so a stalled sink never
  // blocks traffic headed elsewhere.
  assign w_sel_ok = ~w_valid[bus.in_sel] | bus.out_ready[bus.in_sel];

`ifdef DEMUX_BCAST_EN
  logic w_all_ok;
  assign w_all_ok     = &(~w_valid | bus.out_ready);
  assign w_bcast      = in_bcast;
  assign bus.in_ready = w_bcast ? w_all_ok : w_sel_ok;
`else
  assign w_bcast      = 1'b0;
  assign bus.in_ready = w_sel_ok;
`endif

  assign w_fire = bus.in_valid & bus.in_ready;

  always_comb begin
    w_push = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_push[i] = w_fire & (w_bcast | (bus.in_sel == SEL_W'(i)));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    demux_chan_buf u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[g]),
      .i_data  (bus.in_data),
      .i_ready (bus.out_ready[g]),
      .o_valid (w_valid[g]),
      .o_data  (w_data[g]),
      .o_cnt   (w_cnt[g]),
      .o_state (o_dbg_state[g])
    );
  end

  always_comb begin
    bus.out_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.out_cnt[i*CNT_W +: CNT_W] = w_cnt[i];
    end
  end

  assign bus.out_valid = w_valid;
  assign bus.out_data0 = w_data[0];
  assign bus.out_data1 = w_data[1];
  assign bus.out_data2 = w_data[2];
  assign bus.out_data3 = w_data[3];
endmodule

// File: tb/tb_demux1_4_router.sv
// Self-checking bench for demux1_4_router: directed scenarios followed by
// randomized traffic, all checked against a per-channel occupancy model.
module tb_demux1_4_router;
  import demux_pkg::*;

  logic clk;
  logic rst_n;
  logic in_bcast;
  chan_state_t [NUM_CH-1:0] dbg_state;

  demux1_4_router_if bus ();

  demux1_4_router dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef DEMUX_BCAST_EN
    .in_bcast    (in_bcast),
`endif
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each sink holds at most one word; counts are
  // delivered words modulo 2^CNT_W.
  bit                m_full [NUM_CH];
  logic [DATA_W-1:0] m_data [NUM_CH];
  int                m_cnt  [NUM_CH];

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_full[i] = 0;
      m_data[i] = '0;
      m_cnt[i]  = 0;
    end
  endfunction

  function automatic bit model_ready(input logic [1:0] s, input logic [3:0] r, input logic b);
    bit ok;
    if (b) begin
      ok = 1;
      for (int i = 0; i < NUM_CH; i++) if (m_full[i] && !r[i]) ok = 0;
    end else begin
      ok = !m_full[s] || r[s];
    end
    return ok;
  endfunction

  function automatic logic [DATA_W-1:0] dut_data(input int i);
    case (i)
      0: return bus.out_data0;
      1: return bus.out_data1;
      2: return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("valid%0d", i), 64'(bus.out_valid[i]), 64'(m_full[i]));
      chk($sformatf("data%0d", i), 64'(dut_data(i)), 64'(m_data[i]));
      chk($sformatf("cnt%0d", i), 64'(bus.out_cnt[i*CNT_W +: CNT_W]), 64'(m_cnt[i] % 256));
      chk($sformatf("state%0d", i), 64'(dbg_state[i] == FULL), 64'(m_full[i]));
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: applies inputs, checks in_ready, advances the
  // model across the next rising edge, then checks all outputs.
  task automatic step(input logic v, input logic [1:0] s, input logic [15:0] d,
                      input logic [3:0] r, input logic b);
    bit er;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
    in_bcast      = b;
    #1;
    er = model_ready(s, r, b);
    chk("in_ready", 64'(bus.in_ready), 64'(er));
    for (int i = 0; i < NUM_CH; i++) begin
      bit pop, push;
      pop  = m_full[i] && r[i];
      push = v && er && (b || s == 2'(i));
      if (pop) m_cnt[i]++;
      if (push) begin
        m_full[i] = 1;
        m_data[i] = d;
      end else if (pop) begin
        m_full[i] = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n         = 1'b1;
    in_bcast      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    model_reset();

    // Asynchronous reset mid-cycle, observed without a clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_cnt", 64'(bus.out_cnt), 64'h0);
    chk("rst_ready", 64'(bus.in_ready), 64'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // Single route to ch2 with all sinks stalled.
    step(1, 2, 16'hA5A5, 4'b0000, 0);
    chk("sr_valid", 64'(bus.out_valid), 64'b0100);
    chk("sr_data2", 64'(bus.out_data2), 64'hA5A5);
    bus.in_sel = 2;
    #1;
    chk("sr_ready_sel2", 64'(bus.in_ready), 64'h0);

    // Isolation: ch2 stalled must not block ch1.
    step(1, 1, 16'h0001, 4'b0000, 0);
    chk("iso_valid", 64'(bus.out_valid), 64'b0110);
    chk("iso_data2", 64'(bus.out_data2), 64'hA5A5);
    chk("iso_data1", 64'(bus.out_data1), 64'h0001);

    // Stalled push to a full channel is refused and data stays put.
    step(1, 2, 16'h5555, 4'b0000, 0);
    chk("stall_data2", 64'(bus.out_data2), 64'hA5A5);

    // Back-to-back streaming on ch0.
    step(1, 0, 16'h0010, 4'b0001, 0);
    step(1, 0, 16'h0011, 4'b0001, 0);
    chk("b2b_data0a", 64'(bus.out_data0), 64'h0011);
    step(1, 0, 16'h0012, 4'b0001, 0);
    step(0, 0, 16'h0000, 4'b0001, 0);
    chk("b2b_cnt0", 64'(bus.out_cnt[7:0]), 64'd3);
    chk("b2b_empty0", 64'(bus.out_valid[0]), 64'h0);
    chk("b2b_hold0", 64'(bus.out_data0), 64'h0012);

    // Counter wrap on ch3 after 256 deliveries.
    for (int k = 0; k < 256; k++) step(1, 3, 16'($urandom), 4'b1000, 0);
    chk("wrap_cnt3_255", 64'(bus.out_cnt[31:24]), 64'd255);
    step(0, 3, 16'h0000, 4'b1000, 0);
    chk("wrap_cnt3_0", 64'(bus.out_cnt[31:24]), 64'd0);

`ifdef DEMUX_BCAST_EN
    // Broadcast blocked by stalled ch1, then released.
    step(1, 0, 16'hBEEF, 4'b0000, 1);
    chk("bc_blocked", 64'(m_data[0] != 16'hBEEF), 64'h1);
    step(1, 0, 16'hBEEF, 4'b1111, 1);
    chk("bc_valid", 64'(bus.out_valid), 64'hF);
    chk("bc_data0", 64'(bus.out_data0), 64'hBEEF);
    chk("bc_data1", 64'(bus.out_data1), 64'hBEEF);
    chk("bc_data3", 64'(bus.out_data3), 64'hBEEF);
`endif

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic b;
      b = 1'b0;
`ifdef DEMUX_BCAST_EN
      b = ($urandom_range(0, 7) == 0);
`endif
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 16'($urandom),
           4'($urandom), b);
    end

    // Reset while words are held: contents discarded, no pop counted.
    step(1, 0, 16'h1234, 4'b0000, 0);
    step(1, 3, 16'h4321, 4'b0000, 0);
    bus.out_ready = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid", 64'(bus.out_valid), 64'h0);
    chk("mid_rst_cnt", 64'(bus.out_cnt), 64'h0);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
